// File: rtl/address_register_bank_pkg.sv
// +------------------------------------------------------------------+
// | Package : arf_pkg                                                |
// | Shared encodings for the address register bank.                  |
// | Option  : ARF_SATURATE_EN (inc/dec saturate instead of wrapping) |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package arf_pkg;

  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  localparam int IDX_PC = 0;
  localparam int IDX_SP = 1;
  localparam int IDX_AR = 2;

`ifdef ARF_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } arf_state_t;

endpackage

`default_nettype wire

// File: rtl/address_register_bank_address_reg.sv
// +------------------------------------------------------------------+
// | Module  : address_reg                                            |
// | One AW-bit register with dec/inc/load/clear and a priority load. |
// | Option  : ARF_SATURATE_EN (via arf_pkg::SATURATE)                |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module address_reg
  import arf_pkg::*;
#(
  parameter int            AW        = 16,
  parameter logic [AW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [1:0]    i_fun_sel,
  input  logic [AW-1:0] i_data,
  input  logic          i_seq_load,
  input  logic [AW-1:0] i_seq_data,
  output logic [AW-1:0] o_q
);

  logic [AW-1:0] r_q;

  // Sequencer load has priority; the top already masks conflicting writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_seq_load) begin
      r_q <= i_seq_data;
    end else if (i_en) begin
      case (i_fun_sel)
        FS_DEC:  r_q <= (SATURATE && (r_q == '0)) ? r_q : r_q - AW'(1);
        FS_INC:  r_q <= (SATURATE && (&r_q)) ? r_q : r_q + AW'(1);
        FS_LOAD: r_q <= i_data;
        default: r_q <= '0;
      endcase
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/address_register_bank.sv
// +------------------------------------------------------------------+
// | Module  : address_register_bank                                  |
// | PC/SP/AR register bank with CALL/RET stack sequencer.            |
// | Option  : ARF_SATURATE_EN (inc/dec saturate instead of wrapping) |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module address_register_bank
  import arf_pkg::*;
#(
  parameter int            AW          = 16,
  parameter int            NREG        = 4,
  parameter logic [AW-1:0] STACK_BASE  = 'hFFFF,
  parameter logic [AW-1:0] STACK_LIMIT = 'hFF00,
  parameter int            SELW        = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   i_data,
  input  logic [NREG-1:0] i_reg_sel,
  input  logic [1:0]      i_fun_sel,
  input  logic [SELW-1:0] i_out_c_sel,
  input  logic [SELW-1:0] i_out_d_sel,
  output logic [AW-1:0]   o_out_c,
  output logic [AW-1:0]   o_out_d,
  input  logic            i_call_req,
  input  logic            i_ret_req,
  input  logic [AW-1:0]   i_target,
  output logic            o_busy,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [AW-1:0]   o_mem_addr,
  output logic [AW-1:0]   o_mem_wdata,
  input  logic [AW-1:0]   i_mem_rdata,
  input  logic            i_mem_ack,
  output logic            o_stack_fault
);

  arf_state_t    r_state;
  logic [AW-1:0] r_target;
  logic          r_busy;
  logic          r_mem_req;
  logic          r_mem_we;
  logic          r_stack_fault;

  logic [AW-1:0]   w_q        [NREG];
  logic [AW-1:0]   w_rd       [2**SELW];
  logic [NREG-1:0] w_en;
  logic [NREG-1:0] w_seq_load;
  logic [AW-1:0]   w_seq_data [NREG];
  logic [AW-1:0]   w_pc;
  logic [AW-1:0]   w_sp;
  logic [AW-1:0]   w_sp_dec;
  logic [AW-1:0]   w_sp_inc;

  assign w_pc     = w_q[IDX_PC];
  assign w_sp     = w_q[IDX_SP];
  assign w_sp_dec = (SATURATE && (w_sp == '0)) ? w_sp : w_sp - AW'(1);
  assign w_sp_inc = (SATURATE && (&w_sp))      ? w_sp : w_sp + AW'(1);

  // PC and SP belong to the sequencer while a transfer is outstanding.
  always_comb begin
    for (int k = 0; k < NREG; k++) begin
      w_en[k] = i_reg_sel[k] && !(r_busy && ((k == IDX_PC) || (k == IDX_SP)));
    end
  end

  always_comb begin
    w_seq_load = '0;
    for (int k = 0; k < NREG; k++) w_seq_data[k] = '0;
    if (i_mem_ack && (r_state == ST_PUSH)) begin
      w_seq_load[IDX_PC] = 1'b1;
      w_seq_data[IDX_PC] = r_target;
      w_seq_load[IDX_SP] = 1'b1;
      w_seq_data[IDX_SP] = w_sp_dec;
    end else if (i_mem_ack && (r_state == ST_POP)) begin
      w_seq_load[IDX_PC] = 1'b1;
      w_seq_data[IDX_PC] = i_mem_rdata;
      w_seq_load[IDX_SP] = 1'b1;
      w_seq_data[IDX_SP] = w_sp_inc;
    end
  end

  for (genvar k = 0; k < NREG; k++) begin : g_reg
    address_reg #(
      .AW        (AW),
      .RESET_VAL ((k == IDX_SP) ? STACK_BASE : '0)
    ) u_reg (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (w_en[k]),
      .i_fun_sel  (i_fun_sel),
      .i_data     (i_data),
      .i_seq_load (w_seq_load[k]),
      .i_seq_data (w_seq_data[k]),
      .o_q        (w_q[k])
    );
  end

  // Unused select codes past NREG read back as zero.
  for (genvar k = 0; k < 2**SELW; k++) begin : g_rd
    if (k < NREG) begin : g_real
      assign w_rd[k] = w_q[k];
    end else begin : g_pad
      assign w_rd[k] = '0;
    end
  end

  assign o_out_c = w_rd[i_out_c_sel];
  assign o_out_d = w_rd[i_out_d_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_target      <= '0;
      r_busy        <= 1'b0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_stack_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_call_req) begin
            if (w_sp == STACK_LIMIT) begin
              r_stack_fault <= 1'b1;
            end else begin
              r_target  <= i_target;
              r_state   <= ST_PUSH;
              r_busy    <= 1'b1;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b1;
            end
          end else if (i_ret_req) begin
            if (w_sp == STACK_BASE) begin
              r_stack_fault <= 1'b1;
            end else begin
              r_state   <= ST_POP;
              r_busy    <= 1'b1;
              r_mem_req <= 1'b1;
              r_mem_we  <= 1'b0;
            end
          end
        end
        ST_PUSH, ST_POP: begin
          if (i_mem_ack) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  // Address/data follow the live SP/PC so a same-edge RegSel write is honoured.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (r_state == ST_PUSH) begin
      o_mem_addr  = w_sp - AW'(1);
      o_mem_wdata = w_pc;
    end else if (r_state == ST_POP) begin
      o_mem_addr  = w_sp;
    end
  end

  assign o_busy        = r_busy;
  assign o_mem_req     = r_mem_req;
  assign o_mem_we      = r_mem_we;
  assign o_stack_fault = r_stack_fault;

endmodule

`default_nettype wire

// File: tb/tb_address_register_bank.sv
// +------------------------------------------------------------------+
// | Module  : tb_address_register_bank                               |
// | Directed table and sequence checks for address_register_bank.    |
// | Option  : ARF_SATURATE_EN changes the expected inc/dec results   |
// | Rev 1.0 : initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_address_register_bank;

  localparam logic [1:0] F_DEC  = 2'b00;
  localparam logic [1:0] F_INC  = 2'b01;
  localparam logic [1:0] F_LOAD = 2'b10;
  localparam logic [1:0] F_CLR  = 2'b11;

`ifdef ARF_SATURATE_EN
  localparam logic [15:0] EXP_DEC0   = 16'h0000;
  localparam logic [15:0] EXP_INC    = 16'h0001;
  localparam logic [15:0] EXP_INCMAX = 16'hFFFF;
`else
  localparam logic [15:0] EXP_DEC0   = 16'hFFFF;
  localparam logic [15:0] EXP_INC    = 16'h0000;
  localparam logic [15:0] EXP_INCMAX = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  reg_sel = '0;
  logic [1:0]  fun_sel = '0;
  logic [1:0]  out_c_sel = '0;
  logic [1:0]  out_d_sel = '0;
  logic [15:0] out_c;
  logic [15:0] out_d;
  logic        call_req = 1'b0;
  logic        ret_req = 1'b0;
  logic [15:0] target = '0;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stack_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  address_register_bank dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_data        (data),
    .i_reg_sel     (reg_sel),
    .i_fun_sel     (fun_sel),
    .i_out_c_sel   (out_c_sel),
    .i_out_d_sel   (out_d_sel),
    .o_out_c       (out_c),
    .o_out_d       (out_d),
    .i_call_req    (call_req),
    .i_ret_req     (ret_req),
    .i_target      (target),
    .o_busy        (busy),
    .o_mem_req     (mem_req),
    .o_mem_we      (mem_we),
    .o_mem_addr    (mem_addr),
    .o_mem_wdata   (mem_wdata),
    .i_mem_rdata   (mem_rdata),
    .i_mem_ack     (mem_ack),
    .o_stack_fault (stack_fault)
  );

  typedef struct {
    logic [3:0]  sel;
    logic [1:0]  fs;
    logic [15:0] din;
    logic [1:0]  c_sel;
    logic [1:0]  d_sel;
    logic [15:0] exp_c;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string name, input logic [1:0] idx, input logic [15:0] exp);
    out_c_sel = idx;
    #1;
    check(name, out_c, exp);
  endtask

  initial begin
    vecs[0]  = '{4'b0100, F_LOAD, 16'h1234, 2'd2, 2'd3, 16'h1234, 16'h0000};
    vecs[1]  = '{4'b0100, F_DEC,  16'h0000, 2'd2, 2'd3, 16'h1233, 16'h0000};
    vecs[2]  = '{4'b0100, F_DEC,  16'h0000, 2'd2, 2'd0, 16'h1232, 16'h0000};
    vecs[3]  = '{4'b1000, F_LOAD, 16'hABCD, 2'd3, 2'd2, 16'hABCD, 16'h1232};
    vecs[4]  = '{4'b1100, F_INC,  16'h0000, 2'd2, 2'd3, 16'h1233, 16'hABCE};
    vecs[5]  = '{4'b1000, F_CLR,  16'h0000, 2'd3, 2'd2, 16'h0000, 16'h1233};
    vecs[6]  = '{4'b0000, F_LOAD, 16'hFFFF, 2'd2, 2'd3, 16'h1233, 16'h0000};
    vecs[7]  = '{4'b1000, F_DEC,  16'h0000, 2'd3, 2'd1, EXP_DEC0, 16'hFFFF};
    vecs[8]  = '{4'b1000, F_INC,  16'h0000, 2'd3, 2'd0, EXP_INC,  16'h0000};
    vecs[9]  = '{4'b0001, F_LOAD, 16'h0040, 2'd0, 2'd1, 16'h0040, 16'hFFFF};
    vecs[10] = '{4'b0100, F_LOAD, 16'hFFFF, 2'd2, 2'd0, 16'hFFFF, 16'h0040};
    vecs[11] = '{4'b0100, F_INC,  16'h0000, 2'd2, 2'd1, EXP_INCMAX, 16'hFFFF};
    vecs[12] = '{4'b0100, F_LOAD, 16'h0000, 2'd2, 2'd3, 16'h0000, EXP_INC};

    // Reset state
    #12;
    check_reg("rst_pc", 2'd0, 16'h0000);
    check_reg("rst_sp", 2'd1, 16'hFFFF);
    check_reg("rst_ar", 2'd2, 16'h0000);
    check("rst_fault", {15'd0, stack_fault}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_memreq", {15'd0, mem_req}, 16'd0);
    check("rst_memaddr", mem_addr, 16'h0000);
    #1 rst_n = 1'b1;
    tick();

    // Register operations
    for (int i = 0; i < 13; i++) begin
      reg_sel   = vecs[i].sel;
      fun_sel   = vecs[i].fs;
      data      = vecs[i].din;
      out_c_sel = vecs[i].c_sel;
      out_d_sel = vecs[i].d_sel;
      tick();
      check($sformatf("vec%0d_c", i), out_c, vecs[i].exp_c);
      check($sformatf("vec%0d_d", i), out_d, vecs[i].exp_d);
    end
    reg_sel = '0;

    // CALL with ack after three cycles; PC=0040, SP=FFFF
    call_req = 1'b1;
    target   = 16'h0200;
    tick();
    call_req = 1'b0;
    target   = 16'h0000;
    check("call_busy", {15'd0, busy}, 16'd1);
    check("call_we", {15'd0, mem_we}, 16'd1);
    check("call_addr", mem_addr, 16'hFFFE);
    check("call_wdata", mem_wdata, 16'h0040);
    tick();
    tick();
    check("call_req_held", {15'd0, mem_req}, 16'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("call_done_busy", {15'd0, busy}, 16'd0);
    check("call_done_req", {15'd0, mem_req}, 16'd0);
    check_reg("call_pc", 2'd0, 16'h0200);
    check_reg("call_sp", 2'd1, 16'hFFFE);

    // RET
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("ret_req", {15'd0, mem_req}, 16'd1);
    check("ret_we", {15'd0, mem_we}, 16'd0);
    check("ret_addr", mem_addr, 16'hFFFE);
    mem_rdata = 16'h0040;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    check("ret_busy", {15'd0, busy}, 16'd0);
    check_reg("ret_pc", 2'd0, 16'h0040);
    check_reg("ret_sp", 2'd1, 16'hFFFF);

    // RET on empty stack faults
    check("pre_fault", {15'd0, stack_fault}, 16'd0);
    ret_req = 1'b1;
    tick();
    ret_req = 1'b0;
    check("ret_fault", {15'd0, stack_fault}, 16'd1);
    check("ret_fault_req", {15'd0, mem_req}, 16'd0);
    check("ret_fault_busy", {15'd0, busy}, 16'd0);
    tick();
    check("ret_fault_req2", {15'd0, mem_req}, 16'd0);
    check("fault_sticky", {15'd0, stack_fault}, 16'd1);
    check_reg("ret_fault_pc", 2'd0, 16'h0040);
    check_reg("ret_fault_sp", 2'd1, 16'hFFFF);

    // CALL and RET together: CALL wins; PC write blocked, AR write applied
    call_req = 1'b1;
    ret_req  = 1'b1;
    target   = 16'h0300;
    tick();
    call_req = 1'b0;
    ret_req  = 1'b0;
    check("both_we", {15'd0, mem_we}, 16'd1);
    check("both_addr", mem_addr, 16'hFFFE);
    reg_sel = 4'b0101;
    fun_sel = F_LOAD;
    data    = 16'h7777;
    tick();
    reg_sel = '0;
    check_reg("busy_pc_kept", 2'd0, 16'h0040);
    check_reg("busy_ar_written", 2'd2, 16'h7777);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_reg("both_pc", 2'd0, 16'h0300);
    check_reg("both_sp", 2'd1, 16'hFFFE);

    // Reset asserted during PUSH before ack
    call_req = 1'b1;
    target   = 16'h0500;
    tick();
    call_req = 1'b0;
    check("pre_rst_req", {15'd0, mem_req}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req", {15'd0, mem_req}, 16'd0);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    check("rst_mid_fault", {15'd0, stack_fault}, 16'd0);
    check_reg("rst_mid_pc", 2'd0, 16'h0000);
    check_reg("rst_mid_sp", 2'd1, 16'hFFFF);
    check_reg("rst_mid_ar", 2'd2, 16'h0000);
    #1 rst_n = 1'b1;
    tick();

    // CALL at STACK_LIMIT faults without touching registers
    reg_sel = 4'b0010;
    fun_sel = F_LOAD;
    data    = 16'hFF00;
    tick();
    reg_sel  = '0;
    call_req = 1'b1;
    target   = 16'h0600;
    tick();
    call_req = 1'b0;
    check("call_fault", {15'd0, stack_fault}, 16'd1);
    check("call_fault_busy", {15'd0, busy}, 16'd0);
    check_reg("call_fault_sp", 2'd1, 16'hFF00);
    check_reg("call_fault_pc", 2'd0, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
